// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants, colour word layout and the
// flag bundle that travels down the sync/blank alignment pipe.
package vga_timing_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Colour word is {B[11:8], G[7:4], R[3:0]}.
    localparam int COLOR_W     = 4;
    localparam int COLOR_R_LSB = 0;
    localparam int COLOR_G_LSB = 4;
    localparam int COLOR_B_LSB = 8;

    localparam logic [11:0] BLACK = 12'h000;

    // Region flags produced from the counters; hs/vs are active low.
    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
    } scan_flags_t;

    // Blanked, both syncs released: the value the pipe holds in reset.
    localparam scan_flags_t FLAGS_IDLE = '{active: 1'b0, hs: 1'b1, vs: 1'b1};

endpackage

// File: rtl/vga_delay_line.sv
// WIDTH x DEPTH shift register with async reset to RESET_VAL.
// DEPTH = 0 degenerates to a wire.
module vga_delay_line #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             vga_clk,
    input  logic             vga_rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH == 0) begin : g_bypass
        logic unused_clk_rst;
        assign unused_clk_rst = ^{vga_clk, vga_rst_n};
        assign dout = din;
    end else begin : g_pipe
        logic [WIDTH-1:0] stage [DEPTH];

        // Shift din one stage per clock; every stage returns to RESET_VAL in reset.
        // NOTE: these stages are a handful of flops, not a RAM, so resetting
        // them is cheap and required: a stale sync bit must never leak out.
        always_ff @(posedge vga_clk or negedge vga_rst_n) begin
            if (!vga_rst_n) begin
                for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
            end else begin
                stage[0] <= din;
                for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
            end
        end

        assign dout = stage[DEPTH-1];
    end

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA scan timing generator and pin stage. Counters give renderers
// their coordinates; sync and blanking are delayed by the renderer
// latency so colour and sync for the same pixel reach the pins together.
module vga_scan_ctrl #(
    parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int H_FP     = vga_timing_pkg::H_FP,
    parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int H_BP     = vga_timing_pkg::H_BP,
    parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int V_FP     = vga_timing_pkg::V_FP,
    parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int V_BP     = vga_timing_pkg::V_BP,
    parameter int PIPE_DLY = 1
) (
    input  logic        vga_clk,
    input  logic        vga_rst_n,
    input  logic [11:0] pixel_data,
    output logic [9:0]  x_pos,
    output logic [9:0]  y_pos,
    output logic        frame_start,
    output logic        in_vblank,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b
);

    import vga_timing_pkg::scan_flags_t;
    import vga_timing_pkg::FLAGS_IDLE;
    import vga_timing_pkg::BLACK;
    import vga_timing_pkg::COLOR_W;
    import vga_timing_pkg::COLOR_R_LSB;
    import vga_timing_pkg::COLOR_G_LSB;
    import vga_timing_pkg::COLOR_B_LSB;

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
        $error("vga_scan_ctrl: H_TOTAL/V_TOTAL must fit 10-bit counters");
    end
    if (PIPE_DLY < 0 || PIPE_DLY > 3) begin : g_bad_dly
        $error("vga_scan_ctrl: PIPE_DLY must be in 0..3");
    end

    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    scan_flags_t flags_raw;
    scan_flags_t flags_d;
    logic [11:0] colour_sel;

    // Raster counters: h wraps every line, v advances on each h wrap.
    // NOTE: state uses non-blocking (<=) so every flop samples pre-edge
    // values; blocking here would make the result depend on statement order.
    always_ff @(posedge vga_clk or negedge vga_rst_n) begin
        if (!vga_rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == 10'(H_TOTAL - 1)) begin
            h_cnt <= '0;
            if (v_cnt == 10'(V_TOTAL - 1)) v_cnt <= '0;
            else                           v_cnt <= v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    // Decode display region and sync windows from the current counters.
    // NOTE: defaults first so every path assigns every field; no latch.
    always_comb begin
        flags_raw        = FLAGS_IDLE;
        flags_raw.active = (h_cnt < 10'(H_ACTIVE)) && (v_cnt < 10'(V_ACTIVE));
        flags_raw.hs     = !((h_cnt >= 10'(HS_START)) && (h_cnt < 10'(HS_END)));
        flags_raw.vs     = !((v_cnt >= 10'(VS_START)) && (v_cnt < 10'(VS_END)));
    end

    vga_delay_line #(
        .WIDTH     ($bits(scan_flags_t)),
        .DEPTH     (PIPE_DLY),
        .RESET_VAL (FLAGS_IDLE)
    ) u_align (
        .vga_clk   (vga_clk),
        .vga_rst_n (vga_rst_n),
        .din       (flags_raw),
        .dout      (flags_d)
    );

    assign colour_sel = flags_d.active ? pixel_data : BLACK;

    // Pin register: sync from the aligned flags, colour forced black in blanking.
    always_ff @(posedge vga_clk or negedge vga_rst_n) begin
        if (!vga_rst_n) begin
            vga_hs <= 1'b1;
            vga_vs <= 1'b1;
            vga_r  <= '0;
            vga_g  <= '0;
            vga_b  <= '0;
        end else begin
            vga_hs <= flags_d.hs;
            vga_vs <= flags_d.vs;
            vga_r  <= colour_sel[COLOR_R_LSB +: COLOR_W];
            vga_g  <= colour_sel[COLOR_G_LSB +: COLOR_W];
            vga_b  <= colour_sel[COLOR_B_LSB +: COLOR_W];
        end
    end

    assign x_pos       = h_cnt;
    assign y_pos       = v_cnt;
    assign frame_start = (h_cnt == 10'd0) && (v_cnt == 10'd0);
    assign in_vblank   = (v_cnt >= 10'(V_ACTIVE));

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Scoreboard bench for vga_scan_ctrl. Three instances: full 640x480 timing
// with PIPE_DLY=1 fed by an x-coordinate renderer, and two shrunken rasters
// (PIPE_DLY=0 and 3) fed random colour. Expected pin values come from a
// cycle-count model: position = t mod totals, pins show position t-(D+1).
module tb_vga_scan_ctrl;

    typedef struct {
        int ha, hfp, hsw, hbp;
        int va, vfp, vsw, vbp;
        int dly;
        bit x_render;
    } tim_t;

    typedef struct {
        int          t;
        logic [9:0]  x, y;
        logic        fs, vb, hs, vs;
        logic [11:0] rgb;
    } exp_t;

    localparam tim_t TM_D1 = '{ha:640, hfp:16, hsw:96, hbp:48,
                               va:480, vfp:10, vsw:2, vbp:33, dly:1, x_render:1'b1};
    localparam tim_t TM_S0 = '{ha:16, hfp:4, hsw:6, hbp:4,
                               va:12, vfp:2, vsw:2, vbp:3, dly:0, x_render:1'b0};
    localparam tim_t TM_S3 = '{ha:16, hfp:4, hsw:6, hbp:4,
                               va:12, vfp:2, vsw:2, vbp:3, dly:3, x_render:1'b0};
    localparam int SMALL_FRAME = 30 * 19;

    logic        vga_clk;
    logic        vga_rst_n;
    logic [11:0] pix_x;
    logic [11:0] pix_rnd;
    logic [11:0] pix_prev;

    logic [9:0] d1_x, d1_y, s0_x, s0_y, s3_x, s3_y;
    logic       d1_fs, d1_vb, d1_hs, d1_vs;
    logic       s0_fs, s0_vb, s0_hs, s0_vs;
    logic       s3_fs, s3_vb, s3_hs, s3_vs;
    logic [3:0] d1_r, d1_g, d1_b, s0_r, s0_g, s0_b, s3_r, s3_g, s3_b;

    int n_cmp = 0;
    int n_err = 0;
    int t     = -1;

    exp_t q_d1[$];
    exp_t q_s0[$];
    exp_t q_s3[$];

    vga_scan_ctrl u_d1 (
        .vga_clk(vga_clk), .vga_rst_n(vga_rst_n), .pixel_data(pix_x),
        .x_pos(d1_x), .y_pos(d1_y), .frame_start(d1_fs), .in_vblank(d1_vb),
        .vga_hs(d1_hs), .vga_vs(d1_vs), .vga_r(d1_r), .vga_g(d1_g), .vga_b(d1_b)
    );

    vga_scan_ctrl #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3), .PIPE_DLY(0)
    ) u_s0 (
        .vga_clk(vga_clk), .vga_rst_n(vga_rst_n), .pixel_data(pix_rnd),
        .x_pos(s0_x), .y_pos(s0_y), .frame_start(s0_fs), .in_vblank(s0_vb),
        .vga_hs(s0_hs), .vga_vs(s0_vs), .vga_r(s0_r), .vga_g(s0_g), .vga_b(s0_b)
    );

    vga_scan_ctrl #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3), .PIPE_DLY(3)
    ) u_s3 (
        .vga_clk(vga_clk), .vga_rst_n(vga_rst_n), .pixel_data(pix_rnd),
        .x_pos(s3_x), .y_pos(s3_y), .frame_start(s3_fs), .in_vblank(s3_vb),
        .vga_hs(s3_hs), .vga_vs(s3_vs), .vga_r(s3_r), .vga_g(s3_g), .vga_b(s3_b)
    );

    initial begin
        vga_clk = 1'b0;
        forever #5 vga_clk = ~vga_clk;
    end

    // Renderer model for the full-size instance: colour = x of the previous cycle.
    always @(posedge vga_clk) pix_x <= {2'b00, d1_x};

    // Reference model: outputs expected in cycle t (t < 0 means reset held).
    function automatic exp_t predict(input tim_t tm, input int tc, input logic [11:0] pprev);
        exp_t e;
        int ht, vt, tp, hp, vp;
        ht  = tm.ha + tm.hfp + tm.hsw + tm.hbp;
        vt  = tm.va + tm.vfp + tm.vsw + tm.vbp;
        e.t = tc;
        if (tc < 0) begin
            e.x = '0; e.y = '0; e.fs = 1'b1; e.vb = 1'b0;
            e.hs = 1'b1; e.vs = 1'b1; e.rgb = 12'h000;
            return e;
        end
        e.x  = 10'(tc % ht);
        e.y  = 10'((tc / ht) % vt);
        e.fs = (tc % (ht * vt)) == 0;
        e.vb = ((tc / ht) % vt) >= tm.va;
        if (tc < tm.dly + 1) begin
            e.hs = 1'b1; e.vs = 1'b1; e.rgb = 12'h000;
        end else begin
            tp   = tc - tm.dly - 1;
            hp   = tp % ht;
            vp   = (tp / ht) % vt;
            e.hs = !(hp >= tm.ha + tm.hfp && hp < tm.ha + tm.hfp + tm.hsw);
            e.vs = !(vp >= tm.va + tm.vfp && vp < tm.va + tm.vfp + tm.vsw);
            if (hp < tm.ha && vp < tm.va) e.rgb = tm.x_render ? {2'b00, 10'(hp)} : pprev;
            else                          e.rgb = 12'h000;
        end
        return e;
    endfunction

    task automatic check(input string name, input int tc, input logic [31:0] act,
                         input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s t=%0d got %0h expected %0h", name, tc, act, expv);
        end
    endtask

    task automatic cmp_inst(input string tag, input exp_t e, input logic [9:0] x,
                            input logic [9:0] y, input logic fs, input logic vb,
                            input logic hs, input logic vs, input logic [11:0] rgb);
        check({tag, "_x"},   e.t, 32'(x),   32'(e.x));
        check({tag, "_y"},   e.t, 32'(y),   32'(e.y));
        check({tag, "_fs"},  e.t, 32'(fs),  32'(e.fs));
        check({tag, "_vb"},  e.t, 32'(vb),  32'(e.vb));
        check({tag, "_hs"},  e.t, 32'(hs),  32'(e.hs));
        check({tag, "_vs"},  e.t, 32'(vs),  32'(e.vs));
        check({tag, "_rgb"}, e.t, 32'(rgb), 32'(e.rgb));
    endtask

    // Monitor: mid-cycle, pop one expectation per instance and compare.
    always @(negedge vga_clk) begin
        exp_t e;
        if (q_d1.size() != 0) begin
            e = q_d1.pop_front();
            cmp_inst("d1", e, d1_x, d1_y, d1_fs, d1_vb, d1_hs, d1_vs, {d1_b, d1_g, d1_r});
            if (e.t == 5 * 800 + 639 + 2)
                check("d1_px639_line5", e.t, 32'({d1_b, d1_g, d1_r}), 32'h27F);
            if (e.t == 5 * 800 + 640 + 2)
                check("d1_px640_line5_blank", e.t, 32'({d1_b, d1_g, d1_r}), 32'h000);
        end
        if (q_s0.size() != 0) begin
            e = q_s0.pop_front();
            cmp_inst("s0", e, s0_x, s0_y, s0_fs, s0_vb, s0_hs, s0_vs, {s0_b, s0_g, s0_r});
        end
        if (q_s3.size() != 0) begin
            e = q_s3.pop_front();
            cmp_inst("s3", e, s3_x, s3_y, s3_fs, s3_vb, s3_hs, s3_vs, {s3_b, s3_g, s3_r});
        end
    end

    // One stimulus cycle: drive reset and colour just after the edge, push expectations.
    task automatic step(input logic rst_val);
        @(posedge vga_clk);
        #1;
        vga_rst_n = rst_val;
        if (!rst_val) t = -1;
        else          t = t + 1;
        pix_rnd = 12'($urandom_range(1, 4095));
        q_d1.push_back(predict(TM_D1, t, 12'h000));
        q_s0.push_back(predict(TM_S0, t, pix_prev));
        q_s3.push_back(predict(TM_S3, t, pix_prev));
        pix_prev = pix_rnd;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0d got timeout expected finish", t);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vga_rst_n = 1'b0;
        pix_rnd   = 12'h000;
        pix_prev  = 12'h000;

        repeat (10) step(1'b0);
        repeat (5000) step(1'b1);

        // Reset inside both small-raster sync pulses (h=24, v=14).
        while ((t % SMALL_FRAME) != 14 * 30 + 24) step(1'b1);
        repeat ($urandom_range(2, 5)) step(1'b0);
        repeat (1200) step(1'b1);

        for (int i = 0; i < 4 && (q_d1.size() + q_s0.size() + q_s3.size()) != 0; i++)
            @(negedge vga_clk);
        #1;
        check("drain", t, 32'(q_d1.size() + q_s0.size() + q_s3.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
